// File: rtl/uart_tx_monitor.sv
// rtl/uart_tx_monitor.sv - passive 8N1 receiver that snoops a SoC UART TX line
//
// Purpose: recovers bytes from UART_TXD (8 data bits, no parity, 1 stop bit)
// and presents them on a valid/ready output with framing-error and overrun
// pulses.
//
// Configuration macro: UARTMON_FIFO_EN
//   defined   - output buffer is a first-word-fall-through FIFO of 2**FIFO_AW bytes
//   undefined - output buffer is a single holding register (default)
//
// Parameters:
//   BAUD_DIV - XCLK cycles per UART bit (4..65535)
//   FIFO_AW  - FIFO address width, only meaningful with UARTMON_FIFO_EN
//
// Ports:
//   XCLK     in   sole clock, rising edge
//   XRES     in   synchronous active-high reset
//   UART_TXD in   monitored serial line, idle high
//   DATA     out  byte at head of output buffer (0x00 when empty after reset)
//   VALID    out  DATA holds an unconsumed byte
//   READY    in   consumer takes DATA when VALID && READY at a rising edge
//   FERR     out  one-cycle pulse on framing error
//   OVR      out  one-cycle pulse when a completed byte is dropped
//   BUSY     out  receive FSM is not idle

module uart_tx_monitor #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 4
) (
    input  logic       XCLK,
    input  logic       XRES,
    input  logic       UART_TXD,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       FERR,
    output logic       OVR,
    output logic       BUSY
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam logic [TW-1:0] T_LAST = TW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] T_MID  = TW'(BAUD_DIV / 2);

    if (BAUD_DIV < 4 || BAUD_DIV > 65535 || FIFO_AW < 1) begin : g_bad_params
        $error("uart_tx_monitor: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAITHI
    } state_t;

    state_t          state;
    logic            sync1;
    logic            sync2;
    logic            line_d;
    logic [1:0]      prime;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;

    logic            fall;
    logic            mid;
    logic            push;
    logic            full;
    logic            pop;
    logic            accept;

    // The synchronizer holds its reset value for two cycles after release.
    // Edge detection waits until it carries real line samples and line_d
    // starts at 0, so a line already low at release needs a 1 before a 0.
    assign fall = prime[1] && line_d && !sync2;
    assign mid  = (timer == T_MID);
    assign push = (state == S_STOP) && mid && sync2;
    assign BUSY = (state != S_IDLE);

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            prime   <= 2'b00;
            line_d  <= 1'b0;
            state   <= S_IDLE;
            timer   <= '0;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            FERR    <= 1'b0;
        end else begin
            sync1 <= UART_TXD;
            sync2 <= sync1;
            prime <= {prime[0], 1'b1};
            if (prime[1]) begin
                line_d <= sync2;
            end
            FERR <= 1'b0;

            if (state == S_IDLE) begin
                timer <= '0;
            end else if (timer == T_LAST) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    bit_cnt <= 3'd0;
                    if (mid) begin
                        // A line back high at mid start bit was only a glitch.
                        state <= sync2 ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (mid) begin
                        shreg   <= {sync2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (mid) begin
                        if (sync2) begin
                            state <= S_IDLE;
                        end else begin
                            FERR  <= 1'b1;
                            state <= S_WAITHI;
                        end
                    end
                end
                S_WAITHI: begin
                    // A held-low break must not retrigger; wait for idle level.
                    if (sync2) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UARTMON_FIFO_EN
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wptr;
    logic [FIFO_AW:0] rptr;
    logic             empty;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty  = (wptr == rptr);
    assign full   = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                    (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign pop    = !empty && READY;
    assign accept = push && (!full || pop);
    assign VALID  = !empty;
    assign DATA   = empty ? 8'h00 : mem[rptr[FIFO_AW-1:0]];

    always_ff @(posedge XCLK) begin
        if (accept) begin
            mem[wptr[FIFO_AW-1:0]] <= shreg;
        end
    end

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            wptr <= '0;
            rptr <= '0;
            OVR  <= 1'b0;
        end else begin
            OVR <= push && !accept;
            if (accept) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end
`else
    logic [7:0] hold;
    logic       hold_v;

    assign full   = hold_v;
    assign pop    = hold_v && READY;
    assign accept = push && (!full || pop);
    assign VALID  = hold_v;
    assign DATA   = hold;

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            hold   <= 8'h00;
            hold_v <= 1'b0;
            OVR    <= 1'b0;
        end else begin
            OVR <= push && !accept;
            if (accept) begin
                hold   <= shreg;
                hold_v <= 1'b1;
            end else if (pop) begin
                hold_v <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_monitor.sv
// tb/tb_uart_tx_monitor.sv - directed self-checking bench for uart_tx_monitor

module tb_uart_tx_monitor;

    logic       xclk = 1'b0;
    logic       xres = 1'b1;
    logic       txd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int frame_c0 = 0;
    int rise_cyc = -1;
    int ovr_cyc = -1;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic valid_prev = 1'b0;
    logic [7:0] got[$];

    logic       pre_busy, snap_busy, snap_valid, snap_ferr, snap_ovr;
    logic [7:0] snap_data;

    uart_tx_monitor #(.BAUD_DIV(8), .FIFO_AW(2)) dut (
        .XCLK(xclk),
        .XRES(xres),
        .UART_TXD(txd),
        .DATA(data),
        .VALID(valid),
        .READY(ready),
        .FERR(ferr),
        .OVR(ovr),
        .BUSY(busy)
    );

    always #5 xclk = ~xclk;

    always @(posedge xclk) cyc <= cyc + 1;

    always @(negedge xclk) begin
        if (ferr) ferr_cnt++;
        if (ovr) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (valid && !valid_prev) rise_cyc = cyc;
        valid_prev = valid;
        if (valid && ready) got.push_back(data);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge xclk);
        #1;
    endtask

    // One 8N1 frame, 8 clocks per bit; returns #1 after the stop-sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stopv,
                              input logic ready_at_stop, input int reset_at,
                              input logic after);
        for (int i = 0; i < 80; i++) begin
            @(posedge xclk);
            #1;
            if (i == 0) frame_c0 = cyc;
            if (i == reset_at + 1) begin
                snap_busy  = busy;
                snap_valid = valid;
                snap_data  = data;
                snap_ferr  = ferr;
                snap_ovr   = ovr;
                xres = 1'b0;
            end
            if (i < 8) txd = 1'b0;
            else if (i < 72) txd = b[(i - 8) / 8];
            else txd = stopv;
            if (ready_at_stop && i == 79) ready = 1'b1;
            if (i == reset_at) begin
                pre_busy = busy;
                xres = 1'b1;
            end
        end
        @(posedge xclk);
        #1;
        txd = after;
        if (ready_at_stop) ready = 1'b0;
    endtask

    task automatic consume;
        @(posedge xclk);
        #1;
        ready = 1'b1;
        @(posedge xclk);
        #1;
        ready = 1'b0;
    endtask

    task automatic test_reset;
        xres = 1'b1;
        txd = 1'b1;
        ready = 1'b0;
        idle(4);
        @(negedge xclk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", ovr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(posedge xclk);
        #1;
        xres = 1'b0;
        idle(6);
    endtask

    task automatic test_basic;
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        send_frame(8'h55, 1'b1, 1'b0, -10, 1'b1);
        @(negedge xclk);
        #1;
        checks++; if (rise_cyc - frame_c0 !== 80) begin errors++; $display("FAIL basic_latency got %0d want 80", rise_cyc - frame_c0); end
        checks++; if (data !== 8'h55) begin errors++; $display("FAIL basic_data got %h want 55", data); end
        idle(20);
        checks++; if (valid !== 1'b1 || data !== 8'h55) begin errors++; $display("FAIL basic_hold got %b/%h want 1/55", valid, data); end
        ready = 1'b1;
        @(negedge xclk);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_before_pop got %b want 1", valid); end
        @(posedge xclk);
        #1;
        ready = 1'b0;
        @(negedge xclk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %b want 0", valid); end
        checks++; if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin errors++; $display("FAIL basic_flags got %0d/%0d want 0/0", ferr_cnt - f0, ovr_cnt - o0); end
        idle(5);
    endtask

    task automatic test_glitch;
        int f0 = ferr_cnt;
        int done = -1;
        logic saw = 1'b0;
        @(posedge xclk);
        #1;
        txd = 1'b0;
        idle(3);
        txd = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge xclk);
            if (busy) saw = 1'b1;
            else if (saw && done < 0) done = k;
        end
        checks++; if (saw !== 1'b1 || done !== 5) begin errors++; $display("FAIL glitch_busy got saw=%b clear=%0d want saw=1 clear=5", saw, done); end
        checks++; if (valid !== 1'b0 || ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_out got valid=%b ferr=%0d want 0/0", valid, ferr_cnt - f0); end
        idle(5);
    endtask

    task automatic test_ferr;
        int f0 = ferr_cnt;
        send_frame(8'hA3, 1'b0, 1'b0, -10, 1'b1);
        @(negedge xclk);
        #1;
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", ferr_cnt - f0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b want 0", valid); end
        idle(10);
        send_frame(8'h3C, 1'b1, 1'b0, -10, 1'b1);
        @(negedge xclk);
        #1;
        checks++; if (valid !== 1'b1 || data !== 8'h3C) begin errors++; $display("FAIL ferr_next got %b/%h want 1/3c", valid, data); end
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_next_count got %0d want 1", ferr_cnt - f0); end
        consume();
        idle(3);
    endtask

    task automatic test_break;
        int f0 = ferr_cnt;
        send_frame(8'h00, 1'b0, 1'b0, -10, 1'b0);
        idle(40);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_waithi got %b want 1", busy); end
        txd = 1'b1;
        idle(10);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL break_count got %0d want 1", ferr_cnt - f0); end
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL break_state got %b/%b want 0/0", valid, busy); end
    endtask

    task automatic test_overrun;
        int o0 = ovr_cnt;
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, -10, 1'b1);
        idle(5);
        send_frame(8'h22, 1'b1, 1'b0, -10, 1'b1);
        @(negedge xclk);
        #1;
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_count got %0d want 1", ovr_cnt - o0); end
        checks++; if (ovr_cyc - frame_c0 !== 80) begin errors++; $display("FAIL ovr_time got %0d want 80", ovr_cyc - frame_c0); end
        checks++; if (valid !== 1'b1 || data !== 8'h11) begin errors++; $display("FAIL ovr_keep got %b/%h want 1/11", valid, data); end
        consume();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b want 0", valid); end
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b0, -10, 1'b1);
        idle(5);
        send_frame(8'h22, 1'b1, 1'b1, -10, 1'b1);
        @(negedge xclk);
        #1;
        checks++; if (valid !== 1'b1 || data !== 8'h22) begin errors++; $display("FAIL ovr_swap got %b/%h want 1/22", valid, data); end
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL ovr_swap_count got %0d want 0", ovr_cnt - o0); end
        consume();
        idle(3);
    endtask

    task automatic test_fifo;
        int o0 = ovr_cnt;
        logic [7:0] exp;
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            exp = k[7:0];
            send_frame(exp, 1'b1, 1'b0, -10, 1'b1);
            idle(3);
        end
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL fifo_ovr got %0d want 1", ovr_cnt - o0); end
        @(posedge xclk);
        #1;
        ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            exp = k[7:0];
            checks++; if (valid !== 1'b1 || data !== exp) begin errors++; $display("FAIL fifo_drain got %b/%h want 1/%h", valid, data, exp); end
            @(posedge xclk);
            #1;
        end
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fifo_empty got %b want 0", valid); end
        idle(3);
    endtask

    task automatic test_reset_midframe;
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        send_frame(8'hF5, 1'b1, 1'b0, 43, 1'b1);
        checks++; if (pre_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", pre_busy); end
        checks++; if (snap_busy !== 1'b0 || snap_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_state got %b/%b want 0/0", snap_busy, snap_valid); end
        checks++; if (snap_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data got %h want 00", snap_data); end
        checks++; if (snap_ferr !== 1'b0 || snap_ovr !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got %b/%b want 0/0", snap_ferr, snap_ovr); end
        idle(10);
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after got %b/%b want 0/0", valid, busy); end
        checks++; if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin errors++; $display("FAIL mid_flags got %0d/%0d want 0/0", ferr_cnt - f0, ovr_cnt - o0); end
        send_frame(8'h96, 1'b1, 1'b0, -10, 1'b1);
        @(negedge xclk);
        #1;
        checks++; if (valid !== 1'b1 || data !== 8'h96) begin errors++; $display("FAIL mid_next got %b/%h want 1/96", valid, data); end
        consume();
        idle(3);
    endtask

    task automatic test_low_at_release;
        logic saw = 1'b0;
        @(posedge xclk);
        #1;
        xres = 1'b1;
        txd = 1'b0;
        idle(3);
        xres = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge xclk);
            if (busy) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL low_release_busy got %b want 0", saw); end
        @(posedge xclk);
        #1;
        txd = 1'b1;
        idle(10);
        send_frame(8'h5A, 1'b1, 1'b0, -10, 1'b1);
        @(negedge xclk);
        #1;
        checks++; if (valid !== 1'b1 || data !== 8'h5A) begin errors++; $display("FAIL low_release_rx got %b/%h want 1/5a", valid, data); end
        consume();
        idle(3);
    endtask

    task automatic test_back_to_back;
        int n0 = got.size();
        ready = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, -10, 1'b1);
        send_frame(8'h7E, 1'b1, 1'b0, -10, 1'b1);
        idle(4);
        ready = 1'b0;
        checks++; if (got.size() - n0 !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", got.size() - n0); end
        if (got.size() - n0 >= 2) begin
            checks++; if (got[n0] !== 8'h81) begin errors++; $display("FAIL b2b_first got %h want 81", got[n0]); end
            checks++; if (got[n0 + 1] !== 8'h7E) begin errors++; $display("FAIL b2b_second got %h want 7e", got[n0 + 1]); end
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_ferr();
        test_break();
`ifdef UARTMON_FIFO_EN
        test_fifo();
`else
        test_overrun();
`endif
        test_reset_midframe();
        test_low_at_release();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
